// File: rtl/register_file_param_if.sv
// Bus between the issue/writeback stages and the register file: write port,
// two read ports with busy flags, and the scoreboard reservation handshake.
interface register_file_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy1;
  logic              busy2;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ok;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output we, waddr, wdata, ra1, ra2, rsv_valid, rsv_addr,
    input  rdata1, rdata2, busy1, busy2, rsv_ok, busy_cnt
  );

  modport slave (
    input  we, waddr, wdata, ra1, ra2, rsv_valid, rsv_addr,
    output rdata1, rdata2, busy1, busy2, rsv_ok, busy_cnt
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised register file: two bypassed combinational read ports, one write
// port, optional hardwired zero register and a per-register busy scoreboard.
module register_file_param #(
  parameter int DATA_W   = 4,
  parameter int NREGS    = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register_file_param_if.slave  bus
);
  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;
  logic              wr_en;
  logic              rsv_set;

  // Reservation handshake: rsv_valid is the request and rsv_ok the acceptance,
  // both in the same cycle; the requester holds rsv_valid/rsv_addr stable
  // until it sees rsv_ok, and a transfer happens on every edge where both are 1.
  always_comb begin
    wr_en   = bus.we & ~(ZR && (bus.waddr == '0));
    rsv_set = bus.rsv_valid & ~busy_q[bus.rsv_addr] & ~(ZR && (bus.rsv_addr == '0));
  end

  always_comb begin
    bus.rdata1 = regs_q[bus.ra1];
    if (ZR && (bus.ra1 == '0)) begin
      bus.rdata1 = '0;
    end else if (wr_en && (bus.waddr == bus.ra1)) begin
      bus.rdata1 = bus.wdata;
    end
    bus.rdata2 = regs_q[bus.ra2];
    if (ZR && (bus.ra2 == '0)) begin
      bus.rdata2 = '0;
    end else if (wr_en && (bus.waddr == bus.ra2)) begin
      bus.rdata2 = bus.wdata;
    end
  end

  // A write in the current cycle releases its operand; data comes via bypass.
  always_comb begin
    bus.busy1    = busy_q[bus.ra1] & ~(bus.we & (bus.waddr == bus.ra1));
    bus.busy2    = busy_q[bus.ra2] & ~(bus.we & (bus.waddr == bus.ra2));
    bus.rsv_ok   = bus.rsv_valid & ~busy_q[bus.rsv_addr];
    bus.busy_cnt = busy_cnt_q;
  end

  // Release is applied before the reservation so a same-register reservation wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[bus.waddr] = bus.wdata;
      busy_d[bus.waddr] = 1'b0;
    end
    if (rsv_set) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
    busy_cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end
endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: two instances (ZERO_REG=0 and 1) share one
// stimulus stream and are checked against an array-based reference model.
module tb_register_file_param;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic          rsv_valid = 1'b0;
  logic [AW-1:0] rsv_addr = '0;

  register_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  register_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.we = we;        assign bus1.we = we;
  assign bus0.waddr = waddr;  assign bus1.waddr = waddr;
  assign bus0.wdata = wdata;  assign bus1.wdata = wdata;
  assign bus0.ra1 = ra1;      assign bus1.ra1 = ra1;
  assign bus0.ra2 = ra2;      assign bus1.ra2 = ra2;
  assign bus0.rsv_valid = rsv_valid;  assign bus1.rsv_valid = rsv_valid;
  assign bus0.rsv_addr = rsv_addr;    assign bus1.rsv_addr = rsv_addr;

  register_file_param #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  register_file_param #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // reference model: index 0 = plain file, index 1 = file with zero register
  logic [DW-1:0] m_regs [2][NR];
  bit            m_busy [2][NR];
  int            m_cnt  [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit m_wr_ok(int z);
    return we && !(z == 1 && waddr == 0);
  endfunction

  function automatic logic [DW-1:0] m_read(int z, logic [AW-1:0] ra);
    if (z == 1 && ra == 0) return '0;
    if (m_wr_ok(z) && waddr == ra) return wdata;
    return m_regs[z][ra];
  endfunction

  function automatic bit m_busy_rd(int z, logic [AW-1:0] ra);
    return m_busy[z][ra] && !(we && waddr == ra);
  endfunction

  function automatic bit m_rsv_ok(int z);
    return rsv_valid && !m_busy[z][rsv_addr];
  endfunction

  task automatic model_clear();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[z][i] = '0;
        m_busy[z][i] = 1'b0;
      end
      m_cnt[z] = 0;
    end
  endtask

  task automatic model_edge();
    bit ok;
    if (!rst_n) return;
    for (int z = 0; z < 2; z++) begin
      ok = m_rsv_ok(z);
      if (m_wr_ok(z)) begin
        m_regs[z][waddr] = wdata;
        m_busy[z][waddr] = 1'b0;
      end
      if (ok && !(z == 1 && rsv_addr == 0)) m_busy[z][rsv_addr] = 1'b1;
      m_cnt[z] = 0;
      for (int i = 0; i < NR; i++) m_cnt[z] += int'(m_busy[z][i]);
    end
  endtask

  task automatic check_all();
    chk("z0_rdata1", 32'(bus0.rdata1), 32'(m_read(0, ra1)));
    chk("z0_rdata2", 32'(bus0.rdata2), 32'(m_read(0, ra2)));
    chk("z0_busy1", 32'(bus0.busy1), 32'(m_busy_rd(0, ra1)));
    chk("z0_busy2", 32'(bus0.busy2), 32'(m_busy_rd(0, ra2)));
    chk("z0_rsv_ok", 32'(bus0.rsv_ok), 32'(m_rsv_ok(0)));
    chk("z0_busy_cnt", 32'(bus0.busy_cnt), 32'(m_cnt[0]));
    chk("z1_rdata1", 32'(bus1.rdata1), 32'(m_read(1, ra1)));
    chk("z1_rdata2", 32'(bus1.rdata2), 32'(m_read(1, ra2)));
    chk("z1_busy1", 32'(bus1.busy1), 32'(m_busy_rd(1, ra1)));
    chk("z1_busy2", 32'(bus1.busy2), 32'(m_busy_rd(1, ra2)));
    chk("z1_rsv_ok", 32'(bus1.rsv_ok), 32'(m_rsv_ok(1)));
    chk("z1_busy_cnt", 32'(bus1.busy_cnt), 32'(m_cnt[1]));
  endtask

  // driver: inputs are already set; check pre-edge outputs, then take one edge
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    we = 1'b0; rsv_valid = 1'b0;
  endtask

  // asynchronous reset pulse in the middle of a cycle, checked before any edge
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // preload every register and reserve two of them
    for (int i = 0; i < NR; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = DW'($urandom_range(1, 255));
      ra1 = AW'(i); ra2 = AW'((i + 1) % NR);
      tick();
    end
    we = 1'b0; rsv_valid = 1'b1; rsv_addr = 3'd1; tick();
    rsv_addr = 3'd6; tick();
    set_idle(); tick();
    ra1 = 3'd3; ra2 = 3'd6;
    async_reset();

    // readback after write
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5; tick();
    set_idle(); ra1 = 3'd3; tick();
    chk("readback_r3", 32'(bus0.rdata1), 32'h0000_00A5);

    // bypass
    ra1 = 3'd5; ra2 = 3'd5; tick();
    we = 1'b1; waddr = 3'd5; wdata = 8'h3C; #1;
    chk("bypass_rd1", 32'(bus0.rdata1), 32'h0000_003C);
    chk("bypass_rd2", 32'(bus1.rdata2), 32'h0000_003C);
    tick();

    // zero register
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; ra1 = 3'd0; tick();
    set_idle(); tick();
    rsv_valid = 1'b1; rsv_addr = 3'd0; tick();
    set_idle(); tick();

    // scoreboard reserve / refuse / release
    rsv_valid = 1'b1; rsv_addr = 3'd2; ra1 = 3'd2; ra2 = 3'd2; tick();
    tick();
    set_idle(); we = 1'b1; waddr = 3'd2; wdata = 8'h11; tick();
    set_idle(); tick();

    // simultaneous write and reservation of a free register
    we = 1'b1; waddr = 3'd4; wdata = 8'h5A; rsv_valid = 1'b1; rsv_addr = 3'd4;
    ra1 = 3'd4; ra2 = 3'd7; tick();
    set_idle(); tick();

    // fill the scoreboard
    for (int i = 0; i < NR; i++) begin
      rsv_valid = 1'b1; rsv_addr = AW'(i); tick();
    end
    set_idle(); tick();
    chk("fill_cnt_z0", 32'(bus0.busy_cnt), 32'd8);
    chk("fill_cnt_z1", 32'(bus1.busy_cnt), 32'd7);
    async_reset();

    // write and reservation held across an edge during reset are discarded
    rst_n = 1'b0;
    we = 1'b1; waddr = 3'd3; wdata = 8'h77; rsv_valid = 1'b1; rsv_addr = 3'd3;
    ra1 = 3'd3; ra2 = 3'd1;
    tick();
    set_idle();
    #2;
    rst_n = 1'b1;
    tick();

    // randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      we        = 1'($urandom_range(0, 1));
      waddr     = AW'($urandom_range(0, NR - 1));
      wdata     = DW'($urandom_range(0, 255));
      ra1       = AW'($urandom_range(0, NR - 1));
      ra2       = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
      rsv_valid = ($urandom_range(0, 2) != 0);
      rsv_addr  = ($urandom_range(0, 4) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
      tick();
      if ($urandom_range(0, 60) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/register_file_param.md
# register_file_param

Parametrised general-purpose register file for the next-generation RISC core datapath, replacing the fixed 4×4-bit file. It provides two combinational read ports with same-cycle write bypass, one synchronous write port, and an optional hardwired-zero register. A per-register busy scoreboard with a reservation port lets the issue stage stall on operands whose multi-cycle results are still outstanding.

## Interface
- DATA_W, 4, register width in bits (≥1)
- NREGS, 4, number of registers (power of two, ≥2)
- ADDR_W, 2, address width; must equal log2(NREGS)
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and never becomes busy
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- ra1, ra2  input  ADDR_W  read addresses, ports 1 and 2
- rdata1, rdata2  output  DATA_W  read data, ports 1 and 2 (combinational)
- busy1, busy2  output  1  addressed register has an outstanding reservation (combinational)
- rsv_valid  input  1  reservation request: mark rsv_addr busy
- rsv_addr  input  ADDR_W  register to reserve
- rsv_ok  output  1  reservation accepted this cycle (combinational)
- busy_cnt  output  ADDR_W+1  number of busy registers (registered)

## Operation
- State: regs[NREGS] of DATA_W, busy_q[NREGS], busy_cnt.
- Write: on clk, if we and not (ZERO_REG and waddr==0): regs[waddr] <= wdata, busy_q[waddr] <= 0.
- Read port N: if ZERO_REG and raN==0 -> 0; else if we and waddr==raN and the write is not suppressed -> wdata (bypass); else regs[raN].
- busyN = busy_q[raN] & ~(we & waddr==raN). A write in the same cycle releases the operand, with its data supplied through the bypass.
- rsv_ok = rsv_valid & ~busy_q[rsv_addr]. A register already busy cannot be re-reserved; the requester holds rsv_valid until accepted.
- Reservation of register 0 with ZERO_REG=1: rsv_ok=1, no state change.
- On clk, if rsv_ok (and not a zero-reg no-op): busy_q[rsv_addr] <= 1.
- Same register, same cycle, write and accepted reservation: data is written and busy_q ends at 1 (the new reservation wins over the release).
- busy_cnt <= popcount of next-state busy_q. It never exceeds NREGS (or NREGS-1 with ZERO_REG).
- Writes to a non-busy register are legal and leave busy_q at 0.
- Width rules: no arithmetic on data. busy_cnt is ADDR_W+1 bits so NREGS is representable without wrap.

## Timing
- Reset (rst_n=0, asynchronous, any time including mid-operation): all regs=0, busy_q=0, busy_cnt=0, effective immediately without a clock edge.
- Combinational outputs during reset: rdata1/2=0 unless bypassing a concurrent write, busy1/2=0, rsv_ok=rsv_valid.
- Writes and reservations presented while rst_n=0 are discarded.
- Write latency: data visible on a read port in the same cycle via bypass, and from the array from the next cycle onward.
- Reservation: busyN rises the cycle after rsv_ok. busy_cnt updates the same edge.
- Release: busyN falls combinationally in the cycle of the write. busy_cnt decrements at that edge.
- Deassertion of rst_n is synchronised externally. The block assumes release away from the clk edge.

## Test plan
- Reset and readback, DATA_W=8, NREGS=8: pulse rst_n low mid-cycle with regs preloaded -> all rdata=0x00, busy_cnt=0 immediately. Then write 0xA5 to r3 and read it back next cycle -> 0xA5.
- Bypass: we=1, waddr=5, wdata=0x3C with ra1=ra2=5 in the same cycle -> rdata1=rdata2=0x3C before the edge. Old value 0x00 was visible only when we=0.
- Zero register, ZERO_REG=1: write 0xFF to r0 -> rdata1=0 with and without bypass. rsv_valid to r0 -> rsv_ok=1, busy1=0, busy_cnt unchanged.
- Scoreboard: reserve r2 -> rsv_ok=1, busy1(ra1=2)=1 next cycle, busy_cnt=1. Re-reserve r2 -> rsv_ok=0. Write r2=0x11 -> busy1=0 in the same cycle, busy_cnt=0 after the edge.
- Simultaneous write and reserve on a free r4 -> after the edge regs[4]=wdata, busy_q[4]=1, busy_cnt incremented by 1.
- Fill: reserve all NREGS (ZERO_REG=0) -> busy_cnt=NREGS (8=0b1000 for ADDR_W=3), no wrap. Assert rst_n low -> busy_cnt=0 asynchronously.
